// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris lock/clear sequencer.
package tetris_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOCK,
    SETTLE,
    SCAN,
    CLEAR,
    SCORE,
    SPAWN,
    OVER
  } ctrl_state_t;

  localparam logic [1:0] MUX_HOLD  = 2'b00;
  localparam logic [1:0] MUX_LOAD  = 2'b01;
  localparam logic [1:0] MUX_CLEAR = 2'b10;

  localparam int unsigned MAX_SCORE_DEF = 9999;
  localparam logic [2:0]  BATCH_MAX     = 3'd4;
  localparam logic [9:0]  LINES_MAX     = 10'd1023;

  // Points awarded for a batch of 0..4 rows cleared by one piece
  function automatic logic [13:0] pts(input logic [2:0] batch);
    logic [13:0] p;
    case (batch)
      3'd1:    p = 14'd10;
      3'd2:    p = 14'd30;
      3'd3:    p = 14'd50;
      3'd4:    p = 14'd80;
      default: p = 14'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tetris_lock_clear_ctrl_if.sv
// Control/status bundle between the block logic, pixel-map datapath and the sequencer.
interface tetris_lock_clear_ctrl_if #(
  parameter int unsigned ROWS  = 20,
  parameter int unsigned ROW_W = 5
);

  logic             reset_game;
  logic             touchdown;
  logic [ROWS-1:0]  row_full;
  logic             top_occupied;
  logic [1:0]       mux_sel;
  logic             load_real_reg;
  logic             shift_en;
  logic [ROW_W-1:0] shift_row;
  logic             reset_shape;
  logic             busy;
  logic [9:0]       lines_total;
  logic [13:0]      score;
  logic             endgame;

  modport slave (
    input  reset_game, touchdown, row_full, top_occupied,
    output mux_sel, load_real_reg, shift_en, shift_row, reset_shape, busy,
           lines_total, score, endgame
  );

  modport master (
    output reset_game, touchdown, row_full, top_occupied,
    input  mux_sel, load_real_reg, shift_en, shift_row, reset_shape, busy,
           lines_total, score, endgame
  );

endinterface

// File: rtl/tetris_score_accum.sv
// Saturating score and cleared-line accumulators for one game.
module tetris_score_accum
  import tetris_pkg::*;
#(
  parameter int unsigned MAX_SCORE = MAX_SCORE_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clear_i,
  input  logic        line_en_i,
  input  logic        score_en_i,
  input  logic [2:0]  batch_i,
  output logic [13:0] score_o,
  output logic [9:0]  lines_o
);

  logic [13:0] score_q, score_d;
  logic [9:0]  lines_q, lines_d;
  logic [14:0] sum;

  always_comb begin
    sum     = {1'b0, score_q} + {1'b0, pts(batch_i)};
    score_d = score_q;
    lines_d = lines_q;
    if (score_en_i) begin
      score_d = (sum > 15'(MAX_SCORE)) ? 14'(MAX_SCORE) : sum[13:0];
    end
    if (line_en_i && (lines_q != LINES_MAX)) begin
      lines_d = lines_q + 10'd1;
    end
    if (clear_i) begin
      score_d = '0;
      lines_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      score_q <= '0;
      lines_q <= '0;
    end else begin
      score_q <= score_d;
      lines_q <= lines_d;
    end
  end

  assign score_o = score_q;
  assign lines_o = lines_q;

endmodule

// File: rtl/tetris_lock_clear_ctrl.sv
// Piece lock / full-row clear / score / spawn sequencer for the pixel-map datapath.
module tetris_lock_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned ROWS      = 20,
  parameter int unsigned ROW_W     = 5,
  parameter int unsigned MAX_SCORE = MAX_SCORE_DEF
) (
  input logic                     Clk,
  input logic                     Reset,
  tetris_lock_clear_ctrl_if.slave bus
);

  ctrl_state_t      state_q, state_d;
  logic [ROW_W-1:0] ptr_q, ptr_d;
  logic [2:0]       batch_q, batch_d;

  logic [1:0]       mux_sel;
  logic             load_real_reg;
  logic             shift_en;
  logic [ROW_W-1:0] shift_row;
  logic             reset_shape;
  logic             busy;
  logic             endgame;
  logic             score_en;
  logic             line_en;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    batch_d       = batch_q;
    mux_sel       = MUX_HOLD;
    load_real_reg = 1'b0;
    shift_en      = 1'b0;
    shift_row     = '0;
    reset_shape   = 1'b0;
    busy          = 1'b1;
    endgame       = 1'b0;
    score_en      = 1'b0;
    line_en       = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.touchdown) state_d = LOCK;
      end
      LOCK: begin
        mux_sel       = MUX_LOAD;
        load_real_reg = 1'b1;
        ptr_d         = ROW_W'(ROWS - 1);
        batch_d       = '0;
        state_d       = SETTLE;
      end
      // One idle cycle so row_full reflects the freshly written map
      SETTLE: state_d = SCAN;
      SCAN: begin
        if (bus.row_full[ptr_q]) begin
          state_d = CLEAR;
        end else if (ptr_q == '0) begin
          state_d = SCORE;
        end else begin
          ptr_d = ptr_q - 1'b1;
        end
      end
      // ptr stays put: the row that drops into it must be re-checked
      CLEAR: begin
        mux_sel       = MUX_CLEAR;
        load_real_reg = 1'b1;
        shift_en      = 1'b1;
        shift_row     = ptr_q;
        line_en       = 1'b1;
        if (batch_q != BATCH_MAX) batch_d = batch_q + 3'd1;
        state_d = SETTLE;
      end
      SCORE: begin
        score_en = 1'b1;
        state_d  = SPAWN;
      end
      SPAWN: begin
        reset_shape = 1'b1;
        state_d     = bus.top_occupied ? OVER : IDLE;
      end
      OVER: begin
        busy    = 1'b0;
        endgame = 1'b1;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (bus.reset_game) begin
      state_d = IDLE;
      ptr_d   = '0;
      batch_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      batch_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      batch_q <= batch_d;
    end
  end

  tetris_score_accum #(
    .MAX_SCORE(MAX_SCORE)
  ) u_score_accum (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear_i   (bus.reset_game),
    .line_en_i (line_en),
    .score_en_i(score_en),
    .batch_i   (batch_q),
    .score_o   (bus.score),
    .lines_o   (bus.lines_total)
  );

  assign bus.mux_sel       = mux_sel;
  assign bus.load_real_reg = load_real_reg;
  assign bus.shift_en      = shift_en;
  assign bus.shift_row     = shift_row;
  assign bus.reset_shape   = reset_shape;
  assign bus.busy          = busy;
  assign bus.endgame       = endgame;

endmodule

// File: tb/tb_tetris_lock_clear_ctrl.sv
// Directed bench for tetris_lock_clear_ctrl with a row-full model of the pixel map.
module tb_tetris_lock_clear_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b0;

  tetris_lock_clear_ctrl_if #(.ROWS(20), .ROW_W(5)) bus ();

  tetris_lock_clear_ctrl #(
    .ROWS     (20),
    .ROW_W    (5),
    .MAX_SCORE(9999)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  // Row-full model: map written on LOCK from pend, shifted on CLEAR
  logic [19:0] pend = '0;
  logic [19:0] map_q = '0;
  int          lock_cnt = 0;
  int          shift_log[$];
  logic        first_load;
  logic [1:0]  first_mux;

  assign bus.row_full = map_q;

  function automatic logic [19:0] shift_map(input logic [19:0] m, input logic [4:0] r);
    logic [19:0] o;
    o = m;
    for (int i = 19; i >= 1; i--) begin
      if (i <= int'(r)) o[i] = m[i-1];
    end
    o[0] = 1'b0;
    return o;
  endfunction

  always @(posedge Clk) begin
    if (bus.load_real_reg && bus.mux_sel == 2'b01) begin
      map_q    <= pend;
      lock_cnt <= lock_cnt + 1;
    end else if (bus.load_real_reg && bus.mux_sel == 2'b10) begin
      map_q <= shift_map(map_q, bus.shift_row);
    end
    if (bus.shift_en) shift_log.push_back(int'(bus.shift_row));
  end

  // Pulses touchdown, returns the cycle (LOCK = 1) at which reset_shape is seen, -1 on timeout.
  // glitch toggles touchdown while the sequencer is busy.
  task automatic run_piece(input logic [19:0] rows, input logic glitch, output int spawn_n);
    int n;
    pend = rows;
    @(negedge Clk);
    bus.touchdown = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.touchdown = 1'b0;
    n = 1;
    first_load = bus.load_real_reg;
    first_mux  = bus.mux_sel;
    spawn_n = -1;
    while (n < 300) begin
      if (bus.reset_shape) begin
        spawn_n = n;
        break;
      end
      bus.touchdown = glitch & (n % 2 == 1);
      @(negedge Clk);
      n++;
    end
    bus.touchdown = 1'b0;
  endtask

  task automatic pulse_reset_game();
    @(negedge Clk);
    bus.reset_game = 1'b1;
    @(negedge Clk);
    bus.reset_game = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Clk);
    #1;
    total++;
    if ({bus.mux_sel, bus.load_real_reg, bus.shift_en, bus.shift_row, bus.reset_shape,
         bus.busy, bus.endgame} !== 12'd0) begin
      bad++;
      $display("FAIL reset_outputs: got mux=%b load=%b shift=%b row=%0d rs=%b busy=%b end=%b want all 0",
               bus.mux_sel, bus.load_real_reg, bus.shift_en, bus.shift_row, bus.reset_shape,
               bus.busy, bus.endgame);
    end
    total++;
    if (bus.score !== 14'd0 || bus.lines_total !== 10'd0) begin
      bad++;
      $display("FAIL reset_counters: got score=%0d lines=%0d want 0 0", bus.score, bus.lines_total);
    end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_no_rows();
    int sp;
    int l0;
    l0 = lock_cnt;
    run_piece(20'h00000, 1'b0, sp);
    total++;
    if (first_load !== 1'b1 || first_mux !== 2'b01) begin
      bad++;
      $display("FAIL lock_strobe: got load=%b mux=%b want 1 01", first_load, first_mux);
    end
    total++;
    if (sp != 24) begin
      bad++;
      $display("FAIL spawn_latency_empty: got %0d want 24", sp);
    end
    @(negedge Clk);
    total++;
    if (bus.score !== 14'd0 || lock_cnt - l0 != 1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL empty_score: got score=%0d locks=%0d busy=%b want 0 1 0",
               bus.score, lock_cnt - l0, bus.busy);
    end
  endtask

  task automatic test_two_rows();
    int sp;
    shift_log.delete();
    run_piece(20'hC0000, 1'b0, sp);
    // each clear costs CLEAR + SETTLE + one re-scan of the same row
    total++;
    if (sp != 30) begin
      bad++;
      $display("FAIL spawn_latency_two: got %0d want 30", sp);
    end
    total++;
    if (shift_log.size() != 2 || shift_log[0] != 19 || shift_log[1] != 19) begin
      bad++;
      $display("FAIL shift_rows_two: got n=%0d first=%0d want 2 shifts of row 19",
               shift_log.size(), (shift_log.size() > 0) ? shift_log[0] : -1);
    end
    @(negedge Clk);
    total++;
    if (bus.lines_total !== 10'd2 || bus.score !== 14'd30) begin
      bad++;
      $display("FAIL two_rows_score: got lines=%0d score=%0d want 2 30",
               bus.lines_total, bus.score);
    end
  endtask

  task automatic test_reset_mid_scan();
    int n;
    int sp;
    pend = '0;
    @(negedge Clk);
    bus.touchdown = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.touchdown = 1'b0;
    n = 1;
    while (n < 15) begin
      @(negedge Clk);
      n++;
    end
    // cycle 15 is SCAN with ptr = 7
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_scan_busy: got %b want 1", bus.busy);
    end
    Reset = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.mux_sel !== 2'b00 || bus.load_real_reg !== 1'b0 ||
        bus.score !== 14'd0 || bus.lines_total !== 10'd0) begin
      bad++;
      $display("FAIL mid_scan_reset: got busy=%b mux=%b load=%b score=%0d lines=%0d want 0",
               bus.busy, bus.mux_sel, bus.load_real_reg, bus.score, bus.lines_total);
    end
    @(negedge Clk);
    Reset = 1'b1;
    run_piece(20'h00000, 1'b0, sp);
    total++;
    if (sp != 24) begin
      bad++;
      $display("FAIL post_reset_latency: got %0d want 24", sp);
    end
  endtask

  task automatic test_saturate();
    int sp;
    int tmo;
    tmo = 0;
    pulse_reset_game();
    total++;
    if (bus.score !== 14'd0 || bus.lines_total !== 10'd0) begin
      bad++;
      $display("FAIL game_restart: got score=%0d lines=%0d want 0 0", bus.score, bus.lines_total);
    end
    for (int i = 0; i < 124; i++) begin
      run_piece(20'hF0000, 1'b0, sp);
      if (sp < 0) tmo++;
    end
    run_piece(20'hE0000, 1'b0, sp);
    if (sp < 0) tmo++;
    run_piece(20'h80000, 1'b0, sp);
    if (sp < 0) tmo++;
    run_piece(20'h80000, 1'b0, sp);
    if (sp < 0) tmo++;
    @(negedge Clk);
    total++;
    if (tmo != 0 || bus.score !== 14'd9990) begin
      bad++;
      $display("FAIL build_9990: got score=%0d timeouts=%0d want 9990 0", bus.score, tmo);
    end
    run_piece(20'hF0000, 1'b0, sp);
    total++;
    if (sp != 36) begin
      bad++;
      $display("FAIL tetris_latency: got %0d want 36", sp);
    end
    @(negedge Clk);
    total++;
    if (bus.score !== 14'd9999 || bus.lines_total !== 10'd505) begin
      bad++;
      $display("FAIL score_saturate: got score=%0d lines=%0d want 9999 505",
               bus.score, bus.lines_total);
    end
  endtask

  task automatic test_game_over();
    int sp;
    int l0;
    bus.top_occupied = 1'b1;
    run_piece(20'h80000, 1'b0, sp);
    total++;
    if (sp != 27) begin
      bad++;
      $display("FAIL over_spawn: got %0d want 27", sp);
    end
    @(negedge Clk);
    total++;
    if (bus.endgame !== 1'b1 || bus.busy !== 1'b0 || bus.score !== 14'd9999) begin
      bad++;
      $display("FAIL endgame_set: got end=%b busy=%b score=%0d want 1 0 9999",
               bus.endgame, bus.busy, bus.score);
    end
    l0 = lock_cnt;
    bus.touchdown = 1'b1;
    repeat (4) @(negedge Clk);
    bus.touchdown = 1'b0;
    @(negedge Clk);
    total++;
    if (lock_cnt != l0 || bus.endgame !== 1'b1) begin
      bad++;
      $display("FAIL over_ignores_touchdown: got locks=%0d end=%b want 0 1",
               lock_cnt - l0, bus.endgame);
    end
    bus.top_occupied = 1'b0;
    pulse_reset_game();
    total++;
    if (bus.endgame !== 1'b0 || bus.score !== 14'd0 || bus.lines_total !== 10'd0 ||
        bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL over_restart: got end=%b score=%0d lines=%0d busy=%b want 0 0 0 0",
               bus.endgame, bus.score, bus.lines_total, bus.busy);
    end
  endtask

  task automatic test_touchdown_ignored();
    int sp;
    int l0;
    l0 = lock_cnt;
    run_piece(20'h80000, 1'b1, sp);
    repeat (3) @(negedge Clk);
    total++;
    if (sp != 27 || lock_cnt - l0 != 1) begin
      bad++;
      $display("FAIL busy_touchdown: got spawn=%0d locks=%0d want 27 1", sp, lock_cnt - l0);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.score !== 14'd10 || bus.lines_total !== 10'd1) begin
      bad++;
      $display("FAIL busy_touchdown_score: got busy=%b score=%0d lines=%0d want 0 10 1",
               bus.busy, bus.score, bus.lines_total);
    end
  endtask

  initial begin
    bus.reset_game   = 1'b0;
    bus.touchdown    = 1'b0;
    bus.top_occupied = 1'b0;
    test_reset();
    test_no_rows();
    test_two_rows();
    test_reset_mid_scan();
    test_saturate();
    test_game_over();
    test_touchdown_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
